// File: rtl/mux_logic_unit.sv
// Pipelined bitwise logic unit: every result bit is a 2:1 mux selected by an operand-A bit,
// with a valid/ready stream interface and an accumulate (fold) mode. Optional MLU_PARITY_EN adds out_parity.
module mux_logic_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_acc,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_last,
   output logic [CNT_W-1:0] out_beats
`ifdef MLU_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   typedef enum logic [0:0] {
      S_FIRST = 1'b0,
      S_ACC   = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Each op picks the mux data inputs (i0 when sel=0, i1 when sel=1) from {0, 1, b, ~b}.
   function automatic logic [WIDTH-1:0] mux_fn(
      input logic [WIDTH-1:0] sel,
      input logic [WIDTH-1:0] b,
      input logic [2:0]       op
   );
      logic [WIDTH-1:0] i0;
      logic [WIDTH-1:0] i1;
      case (op)
         3'd0: begin i0 = {WIDTH{1'b0}}; i1 = b;               end
         3'd1: begin i0 = b;               i1 = {WIDTH{1'b1}}; end
         3'd2: begin i0 = {WIDTH{1'b1}}; i1 = ~b;              end
         3'd3: begin i0 = b;               i1 = ~b;              end
         3'd4: begin i0 = ~b;              i1 = {WIDTH{1'b0}}; end
         3'd5: begin i0 = ~b;              i1 = b;               end
         3'd6: begin i0 = b;               i1 = b;               end
         3'd7: begin i0 = {WIDTH{1'b1}}; i1 = {WIDTH{1'b0}}; end
         default: begin i0 = {WIDTH{1'b0}}; i1 = {WIDTH{1'b0}}; end
      endcase
      return (sel & i1) | (~sel & i0);
   endfunction

`ifdef MLU_PARITY_EN
   function automatic logic parity_fn(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction
`endif

   state_t           state_r;
   state_t           state_nxt_s;
   logic             advance_s;
   logic             accept_s;
   logic             beat_first_s;
   logic             beat_mode_s;

   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_a_r;
   logic [WIDTH-1:0] s1_b_r;
   logic [2:0]       s1_op_r;
   logic             s1_mode_r;
   logic             s1_last_r;
   logic             s1_first_r;

   logic [WIDTH-1:0] s2_sel_s;
   logic [WIDTH-1:0] s2_y_s;
   logic [CNT_W-1:0] s2_cnt_s;
   logic             s2_emit_s;
   logic             s2_fold_s;

   logic [WIDTH-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_y_r;
   logic             out_last_r;
   logic [CNT_W-1:0] out_beats_r;

   assign advance_s = !out_valid_r || out_ready;
   assign accept_s  = in_valid && advance_s;
   assign in_ready  = advance_s;

   // Packet tracking: classify the incoming beat and pick its mode.
   always_comb begin
      state_nxt_s  = state_r;
      beat_first_s = (state_r == S_FIRST);
      if (beat_first_s) begin
         beat_mode_s = in_acc;
      end else begin
         beat_mode_s = 1'b1;
      end
      if (accept_s) begin
         case (state_r)
            S_FIRST: begin
               if (in_acc && !in_last) begin
                  state_nxt_s = S_ACC;
               end else begin
                  state_nxt_s = S_FIRST;
               end
            end
            S_ACC: begin
               if (in_last) begin
                  state_nxt_s = S_FIRST;
               end else begin
                  state_nxt_s = S_ACC;
               end
            end
            default: state_nxt_s = S_FIRST;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Packet state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_FIRST;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Stage 1: capture the accepted beat with its packet flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {WIDTH{1'b0}};
         s1_b_r     <= {WIDTH{1'b0}};
         s1_op_r    <= 3'd0;
         s1_mode_r  <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_first_r <= 1'b0;
      end else if (advance_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_a_r     <= in_a;
            s1_b_r     <= in_b;
            s1_op_r    <= in_op;
            s1_mode_r  <= beat_mode_s;
            s1_last_r  <= in_last;
            s1_first_r <= beat_first_s;
         end
      end
   end

   // Stage 2 evaluation: later fold beats select on the running accumulator instead of in_a.
   always_comb begin
      if (s1_first_r) begin
         s2_sel_s = s1_a_r;
         s2_cnt_s = CNT_ONE;
      end else begin
         s2_sel_s = acc_r;
         if (cnt_r == CNT_MAX) begin
            s2_cnt_s = cnt_r;
         end else begin
            s2_cnt_s = cnt_r + CNT_ONE;
         end
      end
      s2_y_s    = mux_fn(s2_sel_s, s1_b_r, s1_op_r);
      s2_emit_s = s1_valid_r && (!s1_mode_r || s1_last_r);
      s2_fold_s = s1_valid_r && s1_mode_r;
   end

   // Stage 2 registers: result, accumulator and beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_y_r     <= {WIDTH{1'b0}};
         out_last_r  <= 1'b0;
         out_beats_r <= {CNT_W{1'b0}};
         acc_r       <= {WIDTH{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
      end else if (advance_s) begin
         out_valid_r <= s2_emit_s;
         if (s2_emit_s) begin
            out_y_r     <= s2_y_s;
            out_last_r  <= s1_last_r;
            out_beats_r <= s2_cnt_s;
         end
         if (s2_fold_s) begin
            acc_r <= s2_y_s;
            cnt_r <= s2_cnt_s;
         end
      end
   end

`ifdef MLU_PARITY_EN
   logic out_parity_r;

   // Parity travels with out_y and holds under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_parity_r <= 1'b0;
      end else if (advance_s && s2_emit_s) begin
         out_parity_r <= parity_fn(s2_y_s);
      end
   end

   assign out_parity = out_parity_r;
`endif

   assign out_valid = out_valid_r;
   assign out_y     = out_y_r;
   assign out_last  = out_last_r;
   assign out_beats = out_beats_r;

endmodule

// File: tb/tb_mux_logic_unit.sv
// Directed bench for mux_logic_unit: a packet-level reference model feeds an expected-result
// queue checked on every consumed result, plus literal expectations from the test plan.
module tb_mux_logic_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] in_op;
   logic       in_acc;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic       out_last;
   logic [7:0] out_beats;
`ifdef MLU_PARITY_EN
   logic       out_parity;
`endif

   mux_logic_unit #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_last  (out_last),
      .out_beats (out_beats)
`ifdef MLU_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] y;
      logic       last;
      logic [7:0] beats;
      int         cyc;
   } res_t;

   res_t exp_q[$];
   res_t got_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   lat_chk = 1'b1;

   bit         m_in_pkt = 1'b0;
   logic [7:0] m_acc = 8'h00;
   int         m_cnt = 0;

   bit         prev_hold = 1'b0;
   logic [7:0] prev_y;
   logic       prev_last;
   logic [7:0] prev_beats;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference op table taken straight from the mux definition, bit by bit.
   function automatic logic [7:0] ref_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      logic [7:0] r;
      logic       i0;
      logic       i1;
      for (int i = 0; i < 8; i++) begin
         case (op)
            3'd0: begin i0 = 1'b0;  i1 = b[i];  end
            3'd1: begin i0 = b[i];  i1 = 1'b1;  end
            3'd2: begin i0 = 1'b1;  i1 = ~b[i]; end
            3'd3: begin i0 = b[i];  i1 = ~b[i]; end
            3'd4: begin i0 = ~b[i]; i1 = 1'b0;  end
            3'd5: begin i0 = ~b[i]; i1 = b[i];  end
            3'd6: begin i0 = b[i];  i1 = b[i];  end
            default: begin i0 = 1'b1; i1 = 1'b0; end
         endcase
         r[i] = a[i] ? i1 : i0;
      end
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Model + compare: decisions for the coming edge are taken at the falling edge.
   always @(negedge clk) begin
      res_t e;
      logic [7:0] sel;
      logic [7:0] y;
      bit mode;
      if (rst) begin
         exp_q.delete();
         m_in_pkt  = 1'b0;
         m_acc     = 8'h00;
         m_cnt     = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_y", {24'd0, out_y}, {24'd0, prev_y});
            chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            chk("hold_beats", {24'd0, out_beats}, {24'd0, prev_beats});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", {24'd0, out_y}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("y", {24'd0, out_y}, {24'd0, e.y});
               chk("last", {31'd0, out_last}, {31'd0, e.last});
               chk("beats", {24'd0, out_beats}, {24'd0, e.beats});
`ifdef MLU_PARITY_EN
               chk("parity", {31'd0, out_parity}, {31'd0, ^e.y});
`endif
               if (lat_chk) chk("latency", cyc - e.cyc, 32'd2);
            end
            e.y = out_y; e.last = out_last; e.beats = out_beats; e.cyc = cyc;
            got_log.push_back(e);
         end
         prev_hold  = out_valid && !out_ready;
         prev_y     = out_y;
         prev_last  = out_last;
         prev_beats = out_beats;
         if (in_valid && in_ready) begin
            mode = m_in_pkt ? 1'b1 : in_acc;
            sel  = m_in_pkt ? m_acc : in_a;
            y    = ref_f(sel, in_b, in_op);
            if (mode) begin
               m_cnt = m_in_pkt ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
               m_acc = y;
               if (in_last) begin
                  e.y = y; e.last = 1'b1; e.beats = 8'(m_cnt); e.cyc = cyc;
                  exp_q.push_back(e);
               end
               m_in_pkt = !in_last;
            end else begin
               e.y = y; e.last = in_last; e.beats = 8'd1; e.cyc = cyc;
               exp_q.push_back(e);
            end
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic acc, input logic last);
      bit ok;
      int n;
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [7:0] t1_exp [8];
   int base;

   initial begin
      t1_exp = '{8'h03, 8'h3F, 8'hFC, 8'h3C, 8'hC0, 8'hC3, 8'h33, 8'hF0};
      rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
      in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_y", {24'd0, out_y}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_out_beats", {24'd0, out_beats}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef MLU_PARITY_EN
      chk("rst_parity", {31'd0, out_parity}, 32'd0);
`endif
      @(posedge clk); #1;

      // All eight ops back to back
      out_ready = 1'b1;
      base = got_log.size();
      for (int i = 0; i < 8; i++) send(8'h0F, 8'h33, 3'(i), 1'b0, 1'b1);
      idle(4);
      chk("t1_count", got_log.size() - base, 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (base + i < got_log.size()) begin
            chk("t1_y", {24'd0, got_log[base+i].y}, {24'd0, t1_exp[i]});
            chk("t1_beats", {24'd0, got_log[base+i].beats}, 32'd1);
            if (i > 0) chk("t1_consecutive", got_log[base+i].cyc - got_log[base+i-1].cyc, 32'd1);
         end
      end

      // XOR fold packet; in_acc and in_a ignored after the first beat
      base = got_log.size();
      send(8'hFF, 8'h01, 3'd3, 1'b1, 1'b0);
      send(8'h00, 8'h02, 3'd3, 1'b0, 1'b0);
      send(8'h00, 8'h04, 3'd3, 1'b0, 1'b1);
      idle(4);
      chk("t2_count", got_log.size() - base, 32'd1);
      if (got_log.size() > base) begin
         chk("t2_y", {24'd0, got_log[base].y}, 32'hF8);
         chk("t2_beats", {24'd0, got_log[base].beats}, 32'd3);
         chk("t2_last", {31'd0, got_log[base].last}, 32'd1);
      end

      // Backpressure: two beats held, third waits
      lat_chk = 1'b0;
      out_ready = 1'b0;
      base = got_log.size();
      send(8'hA5, 8'h3C, 3'd0, 1'b0, 1'b0);
      send(8'hA5, 8'h3C, 3'd3, 1'b0, 1'b0);
      in_valid = 1'b1; in_a = 8'h00; in_b = 8'h5A; in_op = 3'd6; in_acc = 1'b0; in_last = 1'b1;
      @(negedge clk);
      chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("t3_out_y_held", {24'd0, out_y}, 32'h24);
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      send(8'h00, 8'h5A, 3'd6, 1'b0, 1'b1);
      idle(5);
      chk("t3_count", got_log.size() - base, 32'd3);
      if (got_log.size() >= base + 3) begin
         chk("t3_y0", {24'd0, got_log[base].y}, 32'h24);
         chk("t3_y1", {24'd0, got_log[base+1].y}, 32'h99);
         chk("t3_y2", {24'd0, got_log[base+2].y}, 32'h5A);
      end
      lat_chk = 1'b1;

      // Reset in the middle of an OR fold packet
      send(8'h01, 8'h02, 3'd1, 1'b1, 1'b0);
      send(8'h00, 8'h04, 3'd1, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      base = got_log.size();
      send(8'h10, 8'h01, 3'd1, 1'b0, 1'b1);
      idle(4);
      chk("t4_count", got_log.size() - base, 32'd1);
      if (got_log.size() > base) chk("t4_y", {24'd0, got_log[base].y}, 32'h11);

      // Beat counter saturation
      base = got_log.size();
      for (int i = 0; i < 300; i++) send(8'hFF, 8'hFF, 3'd0, 1'b1, (i == 299) ? 1'b1 : 1'b0);
      idle(4);
      chk("t5_count", got_log.size() - base, 32'd1);
      if (got_log.size() > base) begin
         chk("t5_y", {24'd0, got_log[base].y}, 32'hFF);
         chk("t5_beats", {24'd0, got_log[base].beats}, 32'd255);
      end

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
